// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus plus the UART TX ready/valid port, shared between
// the memory controller (master) and the memory/IO responder (slave).
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;

  modport master (
    output mem_a, mem_dout, mem_wr, uart_tx_ready,
    input  mem_din, io_buffer_full, uart_tx_valid, uart_tx_data
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, uart_tx_ready,
    output mem_din, io_buffer_full, uart_tx_valid, uart_tx_data
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-side responder: single-port byte RAM with 1-cycle reads, an IO window
// holding a UART TX FIFO and control register, plus sticky halt/overflow flags.
module mem_io_responder #(
  parameter int ADDR_WIDTH     = 17,
  parameter int FIFO_DEPTH_LOG = 3,
  parameter int FULL_MARGIN    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  mem_io_responder_if.slave   bus,
  output logic                halt,
  output logic                tx_overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int CW    = FIFO_DEPTH_LOG + 1;
  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL_C = CW'(DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_t;

  // ---------------------------------------------------------------- decode
  logic                  io_sel;
  logic                  uart_sel;
  logic                  ctrl_sel;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  unused_addr_bits;

  assign io_sel           = (bus.mem_a[17:16] == 2'b11);
  assign uart_sel         = io_sel && (bus.mem_a[15:0] == 16'h0000);
  assign ctrl_sel         = io_sel && (bus.mem_a[15:0] == 16'h0004);
  assign ram_idx          = bus.mem_a[ADDR_WIDTH-1:0];
  assign ram_we           = bus.mem_wr && !io_sel;
  assign unused_addr_bits = ^bus.mem_a[31:18];

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
  logic [7:0] ram_rd_reg;

  // No reset here so the array and its read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (ram_we) begin
        ram[ram_idx] <= bus.mem_dout;
      end
      ram_rd_reg <= ram[ram_idx];
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]                fifo [0:DEPTH-1];
  logic [FIFO_DEPTH_LOG-1:0] wptr_reg;
  logic [FIFO_DEPTH_LOG-1:0] rptr_reg;
  logic [CW-1:0]             count_reg;
  logic [CW-1:0]             count_next;
  logic                      full_reg;
  logic                      push_req;
  logic                      push;
  logic                      pop;
  logic                      drop;

  assign bus.uart_tx_valid = rdy && (count_reg != '0);
  assign bus.uart_tx_data  = fifo[rptr_reg];
  assign pop               = bus.uart_tx_valid && bus.uart_tx_ready;

  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign push_req   = rdy && bus.mem_wr && uart_sel;
  assign push       = push_req && ((count_reg < DEPTH_C) || pop);
  assign drop       = push_req && !push;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wptr_reg] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
    end else begin
      if (push) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (pop) begin
        rptr_reg <= rptr_reg + 1'b1;
      end
      count_reg <= count_next;
      if (rdy) begin
        full_reg <= (count_next >= FULL_LEVEL_C);
      end
    end
  end

  assign bus.io_buffer_full = full_reg;

  // ---------------------------------------------------------------- read path
  rd_src_t    rd_src_reg;
  logic [7:0] io_rdata_reg;

  // mem_din is selected from registers only, so reset clears it at once
  // while the RAM read register itself stays reset-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_src_reg   <= SRC_ZERO;
      io_rdata_reg <= 8'h00;
    end else if (rdy) begin
      if (bus.mem_wr) begin
        rd_src_reg <= SRC_ZERO;
      end else if (io_sel) begin
        rd_src_reg   <= SRC_IO;
        io_rdata_reg <= ctrl_sel ? 8'(count_reg) : 8'h00;
      end else begin
        rd_src_reg <= SRC_RAM;
      end
    end
  end

  always_comb begin
    bus.mem_din = 8'h00;
    case (rd_src_reg)
      SRC_RAM: bus.mem_din = ram_rd_reg;
      SRC_IO:  bus.mem_din = io_rdata_reg;
      default: bus.mem_din = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------- sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rdy && bus.mem_wr && ctrl_sel) begin
        halt <= 1'b1;
      end
      if (drop) begin
        tx_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus; the counterpart of the memory controller that drives mem_a/mem_dout/mem_wr.
- Provides a single-port byte RAM with 1-cycle read latency and a memory-mapped IO window.
- IO writes to the UART address go into a TX FIFO drained by a ready/valid UART port.
- Generates io_buffer_full back to the controller, plus a sticky halt flag for the simulation/FPGA top.

Parameters:
ADDR_WIDTH, 17, RAM byte address width; RAM size is 2^ADDR_WIDTH bytes.
FIFO_DEPTH_LOG, 3, log2 of TX FIFO depth (default depth 8).
FULL_MARGIN, 2, io_buffer_full asserts when occupancy reaches DEPTH-FULL_MARGIN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rdy  input  1  global ready; low freezes all state.
mem_a  input  32  byte address from the controller; only bits 17:0 are decoded.
mem_dout  input  8  write data from the controller.
mem_wr  input  1  1 = write, 0 = read.
mem_din  output  8  read data to the controller (registered).
io_buffer_full  output  1  TX FIFO near-full indication to the controller (registered).
uart_tx_valid  output  1  FIFO head byte is valid.
uart_tx_data  output  8  FIFO head byte.
uart_tx_ready  input  1  UART accepts the byte this cycle.
halt  output  1  sticky; set by a write to 0x30004.
tx_overflow  output  1  sticky; set when a UART write is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_din=0, io_buffer_full=0, halt=0, tx_overflow=0.
  - FIFO read/write pointers and count cleared, so uart_tx_valid=0.
  - RAM contents are not reset.
- Address decode:
  - io = (mem_a[17:16]==2'b11).
  - RAM index = mem_a[ADDR_WIDTH-1:0].
  - IO registers: 0x30000 = UART data, 0x30004 = control.
  - Any other IO offset: writes are ignored, reads return 0x00.
- All state updates below require rdy=1. With rdy=0, the RAM, FIFO, mem_din, io_buffer_full and sticky flags hold their values, and uart_tx_valid is forced to 0, so no pop occurs.
- RAM read (mem_wr=0, !io):
  - mem_din <= ram[index] at the clock edge.
  - Data is visible the cycle after the address; back-to-back reads sustain one byte per cycle.
- RAM write (mem_wr=1, !io):
  - ram[index] <= mem_dout.
  - mem_din <= 0 in that cycle.
  - A read of the same address in the next cycle returns the new value.
- IO read:
  - 0x30000 returns 0x00.
  - 0x30004 returns {4'b0, count}, where count is the occupancy before this cycle's push/pop; count is FIFO_DEPTH_LOG+1 bits, zero-padded/truncated to 8.
  - Latency is 1 cycle, as for RAM.
- IO write to 0x30000 (push):
  - Accepted if count<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set.
- IO write to 0x30004: halt <= 1. halt stays set until reset.
- Pop: occurs when uart_tx_valid && uart_tx_ready.
  - uart_tx_valid = rdy && (count!=0).
  - uart_tx_data = fifo[rptr], combinational from registers.
- Simultaneous push and pop: both occur and count is unchanged; a push into a full FIFO during a pop is legal.
- Pointers wrap modulo DEPTH. count_next = count + push - pop.
- io_buffer_full <= (count_next >= DEPTH-FULL_MARGIN).
  - The 1-cycle lag is covered by FULL_MARGIN: the controller may land one in-flight write after seeing full=1 without overflow.
- Reset mid-operation: the FIFO is flushed; an in-flight read returns 0 (mem_din cleared); halt clears.

Test Plan:
- Write 0xA5 to 0x00010, then 0x3C to 0x1FFFF; read both back-to-back -> mem_din=0xA5 one cycle after the first read address, 0x3C the next cycle.
- Push 6 bytes 0x01..0x06 to 0x30000 with uart_tx_ready=0 (DEPTH=8) -> io_buffer_full=1 the cycle after the 6th push; read 0x30004 -> mem_din=0x06.
- Push 10 bytes with uart_tx_ready=0 -> first 8 stored, tx_overflow=1 after the 9th write; then ready=1 -> uart_tx_data sequence 0x01..0x08, valid drops after 8 pops, io_buffer_full=0.
- FIFO full, push 0x77 with uart_tx_ready=1 in the same cycle -> head popped, 0x77 accepted, count stays 8, tx_overflow stays 0.
- rdy=0 for 3 cycles while writing to RAM and pushing with ready=1 -> no RAM change, no push, uart_tx_valid=0; resume -> state identical to before the stall.
- Write to 0x30004 -> halt=1 next cycle; assert rst low mid-stream -> halt=0, uart_tx_valid=0, mem_din=0 immediately, asynchronously.
